// File: rtl/aqp_esp_uart_tx_if.sv
// Byte-stream handshake into the ESP UART transmitter.
// A byte moves on a clk edge where tx_valid && tx_ready.
interface aqp_esp_uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/aqp_esp_uart_tx.sv
// 8N1 UART transmitter toward the ESP: byte FIFO in front of an LSB-first serializer,
// with frame launches gated by the ESP's active-low CTS.
module aqp_esp_uart_tx #(
  parameter int unsigned CLKS_PER_BIT    = 6,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  aqp_esp_uart_tx_if.slave     tx,
  input  logic                 uart_cts_n,
  output logic                 uart_txd,
  output logic                 tx_busy
);

  localparam int unsigned Depth = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned CntW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic                       cts_meta_q, cts_sync_q, cts_ok;
  logic [7:0]                 mem_q [Depth];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
  state_e                     state_q, state_d;
  logic [CntW-1:0]            clk_cnt_q, clk_cnt_d;
  logic [2:0]                 bit_cnt_q, bit_cnt_d;
  logic [7:0]                 shift_q, shift_d;
  logic                       txd_q, txd_d;
  logic                       push, pop, bit_end, fifo_nonempty, launch_ok;

  assign cts_ok        = ~cts_sync_q;
  assign fifo_nonempty = (count_q != '0);
  assign tx.tx_ready   = (count_q != (FIFO_DEPTH_LOG2 + 1)'(Depth));
  assign push          = tx.tx_valid && tx.tx_ready;
  assign bit_end       = (clk_cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign launch_ok     = fifo_nonempty && cts_ok;
  assign uart_txd      = txd_q;
  assign tx_busy       = fifo_nonempty || (state_q != StIdle);

  // Synchronizer resets to "not clear" so nothing launches before CTS is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cts_meta_q <= 1'b1;
      cts_sync_q <= 1'b1;
    end else begin
      cts_meta_q <= uart_cts_n;
      cts_sync_q <= cts_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx.tx_data;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    txd_d     = txd_q;
    pop       = 1'b0;
    if (state_q == StIdle || bit_end) begin
      clk_cnt_d = '0;
    end else begin
      clk_cnt_d = clk_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        txd_d = 1'b1;
        if (launch_ok) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          txd_d   = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          txd_d     = shift_q[0];
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == 3'd7) begin
            txd_d   = 1'b1;
            state_d = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          // Chain straight into the next start bit when another byte is waiting.
          if (launch_ok) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            txd_d   = 1'b0;
            state_d = StStart;
          end else begin
            txd_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_aqp_esp_uart_tx.sv
// Bench for aqp_esp_uart_tx: directed and random traffic compared cycle by cycle against a
// frame-timeline model (byte queue, frame clock, delayed CTS).
module tb_aqp_esp_uart_tx;

  localparam int CPB   = 6;
  localparam int DEPTH = 8;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic reset;
  logic uart_cts_n;
  logic uart_txd;
  logic tx_busy;

  aqp_esp_uart_tx_if tx_if ();

  aqp_esp_uart_tx #(
    .CLKS_PER_BIT    (CPB),
    .FIFO_DEPTH_LOG2 (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx         (tx_if),
    .uart_cts_n (uart_cts_n),
    .uart_txd   (uart_txd),
    .tx_busy    (tx_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pending bytes, the byte on the wire and cycles since its launch, CTS history.
  logic [7:0] q [$];
  logic [7:0] fb;
  bit         act;
  int         ft;
  logic       c1, c2;
  bit         accepted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic logic exp_txd();
    int idx;
    if (!act) return 1'b1;
    idx = ft / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return fb[idx-1];
  endfunction

  task automatic model_reset();
    q.delete();
    act = 0;
    ft  = 0;
    c1  = 1'b1;
    c2  = 1'b1;
  endtask

  task automatic tick();
    bit         rdy, launch;
    logic [7:0] d;
    @(posedge clk);
    rdy      = q.size() < DEPTH;
    accepted = tx_if.tx_valid && rdy;
    d        = tx_if.tx_data;
    launch   = (!act || ft == FRAME - 1) && q.size() != 0 && (c2 == 1'b0);
    if (launch) begin
      fb  = q.pop_front();
      act = 1;
      ft  = 0;
    end else if (act) begin
      ft++;
      if (ft == FRAME) act = 0;
    end
    if (accepted) q.push_back(d);
    c2 = c1;
    c1 = uart_cts_n;
    #1;
    check("txd", uart_txd, exp_txd());
    check("ready", tx_if.tx_ready, q.size() < DEPTH);
    check("busy", tx_busy, (q.size() != 0) || act);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [7:0] b);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = b;
    tick();
    tx_if.tx_valid = 1'b0;
  endtask

  initial begin
    logic [9:0] pat;
    int         k;
    reset          = 1'b1;
    uart_cts_n     = 1'b0;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    model_reset();
    #23;
    check("rst_txd", uart_txd, 1'b1);
    check("rst_ready", tx_if.tx_ready, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(5);

    // Single byte 0xA5: start, LSB-first data, stop, each held CPB cycles.
    pat = 10'b1101001010;
    push(8'hA5);
    for (int b = 0; b < 10; b++) begin
      run(3);
      check("a5_bit", uart_txd, pat[b]);
      run(CPB - 3);
    end
    run(10);
    check("a5_idle_busy", tx_busy, 1'b0);

    // Back-to-back bytes with no idle gap.
    push(8'h00);
    push(8'hFF);
    push(8'h55);
    run(3 * FRAME + 10);

    // Fill FIFO with CTS held off; 9th byte must be refused.
    uart_cts_n = 1'b1;
    run(3);
    for (int i = 1; i <= 9; i++) begin
      push(8'(i));
      if (i == 8) check("full_ready", tx_if.tx_ready, 1'b0);
    end
    check("full_hold_txd", uart_txd, 1'b1);
    run(20);
    uart_cts_n = 1'b0;
    run(8 * FRAME + 10);

    // CTS dropped mid-frame: frame completes, next waits for CTS.
    push(8'h3C);
    push(8'hC3);
    run(2 + 4 * CPB);
    uart_cts_n = 1'b1;
    run(FRAME + 20);
    check("cts_hold_txd", uart_txd, 1'b1);
    uart_cts_n = 1'b0;
    run(2);
    check("cts_pre_launch", uart_txd, 1'b1);
    run(1);
    check("cts_launch", uart_txd, 1'b0);
    run(FRAME + 5);

    // Reset mid-frame during data bit 4 with bytes still queued.
    push(8'h96);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    k = 0;
    while (!(act && ft == 5 * CPB + 2) && k < 200) begin
      tick();
      k++;
    end
    check("reach_bit4", k < 200, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_txd", uart_txd, 1'b1);
    check("midrst_busy", tx_busy, 1'b0);
    check("midrst_ready", tx_if.tx_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    run(3 * FRAME);

    // Every byte value in sequence.
    for (int i = 0; i < 256; ) begin
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = 8'(i);
      tick();
      if (accepted) i++;
    end
    tx_if.tx_valid = 1'b0;
    run(DEPTH * FRAME + 20);

    // Random traffic with random CTS toggles.
    for (int i = 0; i < 3000; i++) begin
      tx_if.tx_valid = ($urandom_range(0, 3) == 0);
      tx_if.tx_data  = 8'($urandom);
      if ($urandom_range(0, 99) < 3) uart_cts_n = ~uart_cts_n;
      tick();
    end
    tx_if.tx_valid = 1'b0;
    uart_cts_n     = 1'b0;
    run((DEPTH + 1) * FRAME + 10);
    check("drain_busy", tx_busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
